// File: rtl/bcd_serial_subtractor.sv
// ============================================================================
// bcd_serial_subtractor
//
// Digit-serial packed-BCD subtractor: diff = a - b, one decimal digit per
// clock, least significant digit first, with a rippling borrow.
//
// Parameters
//   NDIGITS  number of packed BCD digits per operand (1..8), digit 0 in [3:0]
//
// Ports
//   clk      system clock, all state changes on its rising edge
//   nrst     asynchronous active-low reset
//   start    request pulse, operands sampled when start=1 and idle
//   a        minuend, packed BCD
//   b        subtrahend, packed BCD
//   busy     high while an operation is in progress (RUN and DONE states)
//   done     one-cycle pulse marking valid results
//   diff     packed BCD result
//   borrow   final borrow out (a < b)
//   invalid  an operand digit greater than 9 was sampled
//
// Build option
//   BCD_SUB_SATURATE_EN  when defined, a negative result is clamped to zero
//                        (diff=0, borrow=1) instead of reporting the wrapped
//                        ten's-complement value.
// ============================================================================
module bcd_serial_subtractor #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   diff,
    output logic                   borrow,
    output logic                   invalid
);

    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

`ifdef BCD_SUB_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IW-1:0]   idx;
    logic            borrow_chain;

    logic            operand_bad;
    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic signed [4:0] t;
    logic [3:0]      dig_out;
    logic            dig_bout;

    // Flag any nibble of either incoming operand that is not a decimal digit.
    // Evaluated on the live inputs so it can be latched with the operands.
    always_comb begin
        operand_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                operand_bad = 1'b1;
            end
        end
    end

    // One digit of the subtraction. With valid digits t lies in -10..9,
    // so a 5-bit signed value suffices and t+10 always lands in 0..9.
    // The sign bit of t is exactly the borrow out of this digit.
    always_comb begin
        a_dig    = a_reg[4*idx +: 4];
        b_dig    = b_reg[4*idx +: 4];
        t        = $signed({1'b0, a_dig}) - $signed({1'b0, b_dig})
                 - $signed({4'b0000, borrow_chain});
        dig_bout = t[4];
        dig_out  = t[4] ? 4'(t + 5'sd10) : 4'(t);
    end

    // Control FSM plus datapath registers. All outputs are registered.
    // busy rises on the accepting edge and falls on the edge that raises
    // done, so start is accepted again during the done cycle.
    // Result fix-ups (invalid operands, optional clamp) are applied on the
    // DONE->IDLE edge so diff only ever holds decimal digits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            idx          <= '0;
            borrow_chain <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            diff         <= '0;
            borrow       <= 1'b0;
            invalid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        idx          <= '0;
                        borrow_chain <= 1'b0;
                        diff         <= '0;
                        borrow       <= 1'b0;
                        invalid      <= operand_bad;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end

                RUN: begin
                    if (!invalid) begin
                        diff[4*idx +: 4] <= dig_out;
                    end
                    borrow_chain <= dig_bout;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    if (invalid) begin
                        diff   <= '0;
                        borrow <= 1'b0;
                    end else begin
                        borrow <= borrow_chain;
                        if (SATURATE && borrow_chain) begin
                            diff <= '0;
                        end
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// ============================================================================
// tb_bcd_serial_subtractor
//
// Self-checking bench for bcd_serial_subtractor (NDIGITS=4). Expected results
// come from a decimal-arithmetic model: operands are converted to integers,
// subtracted, wrapped (or clamped when BCD_SUB_SATURATE_EN is defined) and
// converted back to packed BCD.
// ============================================================================
module tb_bcd_serial_subtractor;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk;
    logic          nrst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  diff;
    logic          borrow;
    logic          invalid;

    int tests_run;
    int tests_failed;

    logic [W-1:0]  exp_diff;
    logic          exp_borrow;
    logic          exp_invalid;
    int            done_edge;

    bcd_serial_subtractor #(.NDIGITS(N)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow),
        .invalid (invalid)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: plain decimal arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  output logic [W-1:0] ed, output logic eb,
                                  output logic ei);
        int av, bv, d, modulus;
        logic [3:0] na, nb;
        ei = 1'b0; av = 0; bv = 0; modulus = 1;
        for (int i = N - 1; i >= 0; i--) begin
            na = ta[4*i +: 4];
            nb = tb[4*i +: 4];
            if (na > 4'd9 || nb > 4'd9) ei = 1'b1;
            av = av * 10 + int'(na);
            bv = bv * 10 + int'(nb);
            modulus = modulus * 10;
        end
        ed = '0;
        eb = 1'b0;
        if (!ei) begin
            d = av - bv;
            if (d < 0) begin
                eb = 1'b1;
`ifdef BCD_SUB_SATURATE_EN
                d = 0;
`else
                d = d + modulus;
`endif
            end
            for (int i = 0; i < N; i++) begin
                ed[4*i +: 4] = 4'(d % 10);
                d = d / 10;
            end
        end
    endfunction

    // Random packed-BCD operand, occasionally with one non-decimal nibble.
    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && $urandom_range(0, 7) == 0)
            v[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Pulse start with the given operands (sampled on the next rising edge),
    // scramble the operand inputs afterwards, then wait a bounded number of
    // edges for done. done_edge_o is the edge count after the sampling edge
    // at which done was first seen, or -1 if it never came.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 output int done_edge_o);
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        done_edge_o = -1;
        for (int k = 1; k <= N + 6; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_edge_o = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
        tests_run++; if (diff !== '0) begin tests_failed++; $display("[TB] FAIL reset_diff got %h want 0", diff); end
        tests_run++; if (borrow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_borrow got %b want 0", borrow); end
        tests_run++; if (invalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_invalid got %b want 0", invalid); end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        va[0] = 16'h1234; vb[0] = 16'h0056;
        va[1] = 16'h1000; vb[1] = 16'h0001;
        va[2] = 16'h0000; vb[2] = 16'h0001;
        va[3] = 16'h12A4; vb[3] = 16'h0001;
        va[4] = 16'h0500; vb[4] = 16'h0250;
        va[5] = 16'h9999; vb[5] = 16'h9999;
        for (int i = 0; i < 6; i++) begin
            model(va[i], vb[i], exp_diff, exp_borrow, exp_invalid);
            applyStimulus(va[i], vb[i], done_edge);
            tests_run++; if (done_edge !== N + 1) begin tests_failed++; $display("[TB] FAIL dir%0d_done_edge got %0d want %0d", i, done_edge, N + 1); end
            tests_run++; if (diff !== exp_diff) begin tests_failed++; $display("[TB] FAIL dir%0d_diff %h-%h got %h want %h", i, va[i], vb[i], diff, exp_diff); end
            tests_run++; if (borrow !== exp_borrow) begin tests_failed++; $display("[TB] FAIL dir%0d_borrow got %b want %b", i, borrow, exp_borrow); end
            tests_run++; if (invalid !== exp_invalid) begin tests_failed++; $display("[TB] FAIL dir%0d_invalid got %b want %b", i, invalid, exp_invalid); end
            tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL dir%0d_busy_at_done got %b want 0", i, busy); end
        end
    endtask

    task automatic test_hold();
        model(16'h0321, 16'h0987, exp_diff, exp_borrow, exp_invalid);
        applyStimulus(16'h0321, 16'h0987, done_edge);
        tests_run++; if (done_edge !== N + 1) begin tests_failed++; $display("[TB] FAIL hold_done_edge got %0d want %0d", done_edge, N + 1); end
        @(posedge clk);
        #1;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_done_width got %b want 0", done); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (diff !== exp_diff) begin tests_failed++; $display("[TB] FAIL hold_diff got %h want %h", diff, exp_diff); end
        tests_run++; if (borrow !== exp_borrow) begin tests_failed++; $display("[TB] FAIL hold_borrow got %b want %b", borrow, exp_borrow); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_busy got %b want 0", busy); end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 40; i++) begin
            ra = rand_operand(1'b1);
            rb = rand_operand(1'b1);
            model(ra, rb, exp_diff, exp_borrow, exp_invalid);
            applyStimulus(ra, rb, done_edge);
            tests_run++; if (done_edge !== N + 1) begin tests_failed++; $display("[TB] FAIL rnd%0d_done_edge got %0d want %0d", i, done_edge, N + 1); end
            tests_run++; if (diff !== exp_diff) begin tests_failed++; $display("[TB] FAIL rnd%0d_diff %h-%h got %h want %h", i, ra, rb, diff, exp_diff); end
            tests_run++; if (borrow !== exp_borrow) begin tests_failed++; $display("[TB] FAIL rnd%0d_borrow %h-%h got %b want %b", i, ra, rb, borrow, exp_borrow); end
            tests_run++; if (invalid !== exp_invalid) begin tests_failed++; $display("[TB] FAIL rnd%0d_invalid %h-%h got %b want %b", i, ra, rb, invalid, exp_invalid); end
        end
    endtask

    // Start re-pulsed at edge 2 must be ignored; a start in the done cycle
    // must be accepted.
    task automatic test_back_to_back();
        model(16'h2468, 16'h1357, exp_diff, exp_borrow, exp_invalid);
        @(negedge clk);
        a = 16'h2468; b = 16'h1357; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_busy_run got %b want 1", busy); end
        @(negedge clk);
        a = 16'h9999; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_edge = -1;
        for (int k = 3; k <= N + 8; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_edge = k;
                break;
            end
        end
        tests_run++; if (done_edge !== N + 1) begin tests_failed++; $display("[TB] FAIL b2b_ignored_done_edge got %0d want %0d", done_edge, N + 1); end
        tests_run++; if (diff !== exp_diff) begin tests_failed++; $display("[TB] FAIL b2b_ignored_diff got %h want %h", diff, exp_diff); end
        tests_run++; if (borrow !== exp_borrow) begin tests_failed++; $display("[TB] FAIL b2b_ignored_borrow got %b want %b", borrow, exp_borrow); end

        model(16'h0042, 16'h0777, exp_diff, exp_borrow, exp_invalid);
        applyStimulus(16'h0042, 16'h0777, done_edge);
        tests_run++; if (done_edge !== N + 1) begin tests_failed++; $display("[TB] FAIL b2b_second_done_edge got %0d want %0d", done_edge, N + 1); end
        tests_run++; if (diff !== exp_diff) begin tests_failed++; $display("[TB] FAIL b2b_second_diff got %h want %h", diff, exp_diff); end
        tests_run++; if (borrow !== exp_borrow) begin tests_failed++; $display("[TB] FAIL b2b_second_borrow got %b want %b", borrow, exp_borrow); end
    endtask

    // Reset just after edge 3 of an operation: outputs clear at once, no
    // done pulse follows, and the next operation runs normally.
    task automatic test_mid_reset();
        logic saw_done;
        @(negedge clk);
        a = 16'h4321; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        tests_run++; if (diff !== '0) begin tests_failed++; $display("[TB] FAIL midrst_diff got %h want 0", diff); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_done got %b want 0", done); end
        @(negedge clk);
        nrst = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        tests_run++; if (saw_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_no_done got %b want 0", saw_done); end

        model(16'h0500, 16'h0250, exp_diff, exp_borrow, exp_invalid);
        applyStimulus(16'h0500, 16'h0250, done_edge);
        tests_run++; if (done_edge !== N + 1) begin tests_failed++; $display("[TB] FAIL midrst_next_done_edge got %0d want %0d", done_edge, N + 1); end
        tests_run++; if (diff !== exp_diff) begin tests_failed++; $display("[TB] FAIL midrst_next_diff got %h want %h", diff, exp_diff); end
        tests_run++; if (borrow !== exp_borrow) begin tests_failed++; $display("[TB] FAIL midrst_next_borrow got %b want %b", borrow, exp_borrow); end
    endtask

    // Scenario sequence and summary.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_serial_subtractor.md
BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of packed BCD digits per operand (range 1..8).
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port nrst, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request pulse; operands are sampled when start=1 and the block is idle.
REQ-005 SHALL have port a, input, 4*NDIGITS, minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port b, input, 4*NDIGITS, subtrahend, packed BCD, same packing.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 SHALL have port diff, output, 4*NDIGITS, packed BCD result.
REQ-010 SHALL have port borrow, output, 1, final borrow out (a < b).
REQ-011 SHALL have port invalid, output, 1, an operand digit greater than 9 was sampled.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after NDIGITS digit cycles; DONE->IDLE unconditionally.
REQ-013 SHALL, on the edge sampling start in IDLE, latch a and b, clear the digit index, the borrow chain and the diff register, and evaluate invalid.
REQ-014 SHALL process exactly one digit per RUN cycle, LSD first: t = a_i - b_i - bin; if t<0 then digit = t+10 and bout=1, else digit = t and bout=0.
REQ-015 SHALL use at least 5-bit signed intermediate per digit; no digit written to diff may exceed 9.
REQ-016 SHALL assert busy in RUN and DONE; busy=0 only in IDLE.
REQ-017 SHALL assert done for exactly one cycle, NDIGITS+1 rising edges after the edge that sampled start.
REQ-018 SHALL hold diff, borrow, invalid stable from done until the next accepted start.
REQ-019 SHALL ignore start while busy=1; no relatch, no restart.
REQ-020 SHALL accept start in the cycle immediately after DONE (back-to-back operations).
REQ-021 SHALL, when invalid=1, still run the full NDIGITS cycles but report diff=0 and borrow=0.
REQ-022 SHALL set borrow to the borrow out of digit NDIGITS-1.

Reset
REQ-023 SHALL, while nrst=0, force state IDLE, busy=0, done=0, diff=0, borrow=0, invalid=0, index=0, borrow chain=0, operand latches=0.
REQ-024 SHALL abandon any in-progress operation on reset with no done pulse; the first start after release SHALL be processed normally.

Configuration
REQ-025 SHALL recognise macro BCD_SUB_SATURATE_EN.
REQ-026 SHALL, with BCD_SUB_SATURATE_EN defined, report diff=0 and borrow=1 when the final borrow is 1 (clamp at zero).
REQ-027 SHALL, without BCD_SUB_SATURATE_EN, report the wrapped ten's-complement diff with borrow=1 when the final borrow is 1.

Verification
REQ-028 SHALL cover: NDIGITS=4, a=0x1234, b=0x0056, start pulse -> done at edge 5, diff=0x1178, borrow=0, invalid=0.
REQ-029 SHALL cover: a=0x1000, b=0x0001 -> diff=0x0999, borrow=0 (borrow ripples three digits).
REQ-030 SHALL cover: a=0x0000, b=0x0001 -> diff=0x9999, borrow=1 without the macro; diff=0x0000, borrow=1 with it.
REQ-031 SHALL cover: a=0x12A4, b=0x0001 -> invalid=1, diff=0x0000, borrow=0, done still at edge 5.
REQ-032 SHALL cover: start re-pulsed with a=0x9999 at edge 2 of an operation -> ignored, original result reported; a second start on the cycle after done -> accepted.
REQ-033 SHALL cover: nrst asserted at edge 3 mid-operation -> all outputs 0 immediately, no done pulse; next start with 0x0500-0x0250 -> diff=0x0250, borrow=0.
